// File: rtl/swg_pkg.sv
// ---------------------------------------------------------------------------
// swg_pkg
// Shared definitions for the 3x3 sliding window generator:
//   - tap index constants for the window, tap t = (dy+1)*3 + (dx+1)
//   - the frame FSM state type
//   - counter width helpers used to size column/row counters
// No ports (package).
// ---------------------------------------------------------------------------
package swg_pkg;

  localparam int TAP_NW = 0;
  localparam int TAP_N  = 1;
  localparam int TAP_NE = 2;
  localparam int TAP_W  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_E  = 5;
  localparam int TAP_SW = 6;
  localparam int TAP_S  = 7;
  localparam int TAP_SE = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } swg_state_e;

  // Never return a zero width, even for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int col_w(input int width);
    return cnt_w(width);
  endfunction

  function automatic int row_w(input int height);
    return cnt_w(height);
  endfunction

endpackage

// File: rtl/swg_line_buf.sv
// ---------------------------------------------------------------------------
// swg_line_buf
// Single-clock line buffer RAM, one write and one read per cycle.
// The read port is combinational so a read of the address being written in
// the same cycle returns the old contents (read-before-write), which is what
// lets one buffer hand its row to the next buffer in the chain.
// Contents are never reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational)
// ---------------------------------------------------------------------------
module swg_line_buf
  import swg_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int DW    = 8,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sliding_window_gen.sv
// ---------------------------------------------------------------------------
// sliding_window_gen
// Turns a raster-order pixel stream into zero-padded 3x3 windows, one per
// pixel, or passes pixels through as 1x1 windows (centre tap only).
// Optional feature macro: SWG_STRIDE2_EN -- when defined and stride2 is high
// at frame start, only windows centred on even row / even column assert
// vld_o. Without it, stride2 is ignored.
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-high reset
//   is_conv3x3  in   1 = 3x3 windows, 0 = 1x1 passthrough (sampled per frame)
//   stride2     in   stride-2 decimation request (sampled per frame)
//   vld_i       in   input pixel valid
//   rdy_o       out  block can accept a pixel
//   din         in   pixel, channel k at [k*WI +: WI]
//   win         out  window, tap t at [t*CH*WI +: CH*WI]
//   vld_o       out  one-cycle pulse per window
//   frame_done  out  one-cycle pulse after the last window of a frame
// ---------------------------------------------------------------------------
module sliding_window_gen
  import swg_pkg::*;
#(
  parameter int WI     = 8,
  parameter int CH     = 1,
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                is_conv3x3,
  input  logic                stride2,
  input  logic                vld_i,
  output logic                rdy_o,
  input  logic [CH*WI-1:0]    din,
  output logic [9*CH*WI-1:0]  win,
  output logic                vld_o,
  output logic                frame_done
);

  localparam int PW = CH * WI;
  localparam int CW = col_w(WIDTH);
  localparam int RW = row_w(HEIGHT);
  localparam int FW = cnt_w(WIDTH + 1);

  localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(WIDTH);

  swg_state_e state_q, state_d;
  logic       mode3_q, mode3_d;

  logic [CW-1:0] in_col_q, in_col_d;
  logic [RW-1:0] in_row_q, in_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [FW-1:0] flush_q, flush_d;

  // Column registers, index 0 = top row, 1 = middle, 2 = bottom.
  logic [2:0][PW-1:0] left_q, left_d;
  logic [2:0][PW-1:0] mid_q, mid_d;
  logic [2:0][PW-1:0] new_col;

  logic [9*PW-1:0] win_q, win_d;
  logic [9*PW-1:0] win3, win1;
  logic            vld_q, vld_d;
  logic            done_q, done_d;

  logic [PW-1:0] top_rd, mid_rd;

  logic accept, mode3_eff, last_px, primed;
  logic lb_we, shift, emit, keep;
  logic pad_n, pad_s, pad_w, pad_e;

  assign rdy_o     = (state_q == IDLE) || (state_q == RUN);
  assign accept    = vld_i && rdy_o;
  assign mode3_eff = (state_q == IDLE) ? is_conv3x3 : mode3_q;
  assign last_px   = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);

  // A 3x3 window needs the pixel diagonally below-right of its centre, so
  // the first window only leaves once pixel WIDTH+1 has arrived.
  assign primed = (in_row_q > RW'(1)) || ((in_row_q == RW'(1)) && (in_col_q != '0));

`ifdef SWG_STRIDE2_EN
  logic s2_q, s2_d;
  logic s2_eff;

  assign s2_d   = ((state_q == IDLE) && accept) ? stride2 : s2_q;
  assign s2_eff = (state_q == IDLE) ? stride2 : s2_q;
  assign keep   = !s2_eff || (!out_row_q[0] && !out_col_q[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_q <= 1'b0;
    end else begin
      s2_q <= s2_d;
    end
  end
`else
  logic unused_stride2;

  assign unused_stride2 = stride2;
  assign keep           = 1'b1;
`endif

  // Two chained line buffers: mid holds the previous row, top the one
  // before it. On each accepted pixel mid's old entry moves into top.
  swg_line_buf #(.DEPTH(WIDTH), .DW(PW), .AW(CW)) u_lb_top (
    .clk   (clk),
    .we    (lb_we),
    .waddr (in_col_q),
    .wdata (mid_rd),
    .raddr (in_col_q),
    .rdata (top_rd)
  );

  swg_line_buf #(.DEPTH(WIDTH), .DW(PW), .AW(CW)) u_lb_mid (
    .clk   (clk),
    .we    (lb_we),
    .waddr (in_col_q),
    .wdata (din),
    .raddr (in_col_q),
    .rdata (mid_rd)
  );

  // During flush the incoming column lies below the frame; it is padded
  // anyway, but feeding zeros keeps stray input off the datapath.
  always_comb begin
    new_col[0] = top_rd;
    new_col[1] = mid_rd;
    new_col[2] = (state_q == FLUSH) ? '0 : din;
  end

  // Padding comes purely from the output centre position so stale buffer
  // contents from earlier frames can never leak into a window.
  assign pad_n = (out_row_q == '0);
  assign pad_s = (out_row_q == ROW_LAST);
  assign pad_w = (out_col_q == '0);
  assign pad_e = (out_col_q == COL_LAST);

  always_comb begin
    win3 = '0;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        if (!((dy == 0 && pad_n) || (dy == 2 && pad_s) ||
              (dx == 0 && pad_w) || (dx == 2 && pad_e))) begin
          case (dx)
            0:       win3[(dy*3+dx)*PW +: PW] = left_q[dy[1:0]];
            1:       win3[(dy*3+dx)*PW +: PW] = mid_q[dy[1:0]];
            default: win3[(dy*3+dx)*PW +: PW] = new_col[dy[1:0]];
          endcase
        end
      end
    end
  end

  always_comb begin
    win1 = '0;
    win1[TAP_C*PW +: PW] = din;
  end

  // Frame sequencing: input counters, column shift, window emission and
  // output position tracking.
  always_comb begin
    state_d   = state_q;
    mode3_d   = mode3_q;
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    flush_d   = flush_q;
    left_d    = left_q;
    mid_d     = mid_q;
    win_d     = win_q;
    vld_d     = 1'b0;
    done_d    = 1'b0;
    lb_we     = 1'b0;
    shift     = 1'b0;
    emit      = 1'b0;

    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          state_d = RUN;
          if (state_q == IDLE) begin
            mode3_d = is_conv3x3;
          end
          if (in_col_q == COL_LAST) begin
            in_col_d = '0;
            in_row_d = in_row_q + 1'b1;
          end else begin
            in_col_d = in_col_q + 1'b1;
          end
          if (mode3_eff) begin
            lb_we = 1'b1;
            shift = 1'b1;
            emit  = primed;
            if (last_px) begin
              state_d  = FLUSH;
              in_row_d = '0;
            end
          end else begin
            emit = 1'b1;
            if (last_px) begin
              state_d  = DONE;
              in_row_d = '0;
            end
          end
        end
      end
      FLUSH: begin
        shift    = 1'b1;
        emit     = 1'b1;
        in_col_d = (in_col_q == COL_LAST) ? '0 : in_col_q + 1'b1;
        flush_d  = flush_q + 1'b1;
        if (flush_q == FLUSH_LAST) begin
          state_d = DONE;
          flush_d = '0;
        end
      end
      DONE: begin
        done_d    = 1'b1;
        state_d   = IDLE;
        in_col_d  = '0;
        in_row_d  = '0;
        out_col_d = '0;
        out_row_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (shift) begin
      left_d = mid_q;
      mid_d  = new_col;
    end

    if (emit) begin
      win_d = mode3_eff ? win3 : win1;
      vld_d = keep;
      if (out_col_q == COL_LAST) begin
        out_col_d = '0;
        out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
      end else begin
        out_col_d = out_col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode3_q   <= 1'b0;
      in_col_q  <= '0;
      in_row_q  <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      flush_q   <= '0;
      left_q    <= '0;
      mid_q     <= '0;
      win_q     <= '0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode3_q   <= mode3_d;
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
      flush_q   <= flush_d;
      left_q    <= left_d;
      mid_q     <= mid_d;
      win_q     <= win_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
    end
  end

  assign win        = win_q;
  assign vld_o      = vld_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_sliding_window_gen.sv
// ---------------------------------------------------------------------------
// tb_sliding_window_gen
// Directed bench for a 4x4 single-channel frame using the ramp image
// pixel(r,c) = r*4 + c + 1. Windows are logged on the falling edge and then
// compared against hand-computed constants and a padded-window model.
// ---------------------------------------------------------------------------
module tb_sliding_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_conv3x3 = 1'b0;
  logic        stride2 = 1'b0;
  logic        vld_i = 1'b0;
  logic        rdy_o;
  logic [7:0]  din = 8'h00;
  logic [71:0] win;
  logic        vld_o;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int doneCnt = 0;
  int doneCyc = 0;

  logic [71:0] winQ[$];
  int          winCyc[$];
  int          accCyc[$];
  int          expR[$];
  int          expC[$];

  sliding_window_gen #(.WI(8), .CH(1), .WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .is_conv3x3 (is_conv3x3),
    .stride2    (stride2),
    .vld_i      (vld_i),
    .rdy_o      (rdy_o),
    .din        (din),
    .win        (win),
    .vld_o      (vld_o),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every window and frame_done pulse away from the active edge.
  always @(negedge clk) begin
    if (vld_o) begin
      winQ.push_back(win);
      winCyc.push_back(cyc);
    end
    if (frame_done) begin
      doneCnt = doneCnt + 1;
      doneCyc = cyc;
    end
  end

  // Zero-padded 3x3 window of the ramp image centred on (r,c).
  function automatic logic [71:0] goldWin(input int r, input int c);
    logic [71:0] w;
    int rr;
    int cc;
    w = '0;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        rr = r + dy - 1;
        cc = c + dx - 1;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
          w[(dy*3+dx)*8 +: 8] = 8'(rr * W + cc + 1);
        end
      end
    end
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one pixel after an idle gap and hold it until accepted.
  task automatic applyStimulus(input logic [7:0] px, input int gap);
    logic rdyNow;
    int   guard;
    vld_i = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    din    = px;
    vld_i  = 1'b1;
    guard  = 0;
    rdyNow = 1'b0;
    while (!rdyNow && guard < 50) begin
      rdyNow = rdy_o;
      @(posedge clk);
      #1;
      guard = guard + 1;
    end
    if (!rdyNow) begin
      checkOutput("accept_timeout", 72'(rdyNow), 72'(1));
    end
    accCyc.push_back(cyc);
    vld_i = 1'b0;
  endtask

  task automatic clearLog();
    winQ.delete();
    winCyc.delete();
    accCyc.delete();
    doneCnt = 0;
    doneCyc = 0;
  endtask

  task automatic sendFrame(input int maxGap);
    int g;
    for (int p = 0; p < W * H; p++) begin
      g = (maxGap == 0) ? 0 : int'($urandom_range(0, maxGap));
      applyStimulus(8'(p + 1), g);
    end
  endtask

  task automatic waitDone(input string tag);
    int guard;
    guard = 0;
    while (doneCnt == 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard = guard + 1;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_done_cnt"}, 72'(doneCnt), 72'(1));
  endtask

  task automatic checkRaster(input string tag);
    checkOutput({tag, "_count"}, 72'(winQ.size()), 72'(W * H));
    for (int i = 0; i < winQ.size() && i < W * H; i++) begin
      checkOutput($sformatf("%s_win%0d", tag, i), winQ[i], goldWin(i / W, i % W));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_win", win, 72'h0);
    checkOutput("rst_vld", 72'(vld_o), 72'(0));
    checkOutput("rst_done", 72'(frame_done), 72'(0));
    checkOutput("rst_rdy", 72'(rdy_o), 72'(1));
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // 3x3 gap-free frame, flush shape and latency
    $display("[TB] 3x3 gap-free frame");
    is_conv3x3 = 1'b1;
    clearLog();
    sendFrame(0);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("flush_rdy%0d", k), 72'(rdy_o), 72'(0));
      @(posedge clk);
      #1;
    end
    checkOutput("flush_rdy_after", 72'(rdy_o), 72'(1));
    waitDone("c3");
    checkOutput("c3_corner00", winQ[0], 72'h060500020100000000);
    checkOutput("c3_interior11", winQ[5], 72'h0B0A09070605030201);
    checkOutput("c3_corner33", winQ[15], 72'h00000000100F000C0B);
    checkOutput("c3_latency", 72'(winCyc[0]), 72'(accCyc[5]));
    checkOutput("c3_last_run_latency", 72'(winCyc[10]), 72'(accCyc[15]));
    checkOutput("c3_flush_b2b", 72'(winCyc[15] - winCyc[10]), 72'(5));
    checkOutput("c3_done_timing", 72'(doneCyc), 72'(winCyc[15] + 1));
    checkRaster("c3");

    // 1x1 passthrough
    $display("[TB] 1x1 frame");
    is_conv3x3 = 1'b0;
    clearLog();
    applyStimulus(8'h7F, 0);
    for (int p = 1; p < W * H; p++) begin
      applyStimulus(8'(p + 1), 0);
    end
    waitDone("p1");
    checkOutput("p1_first", winQ[0], 72'h0000007F00000000);
    checkOutput("p1_latency", 72'(winCyc[0]), 72'(accCyc[0]));
    checkOutput("p1_count", 72'(winQ.size()), 72'(16));
    checkOutput("p1_last", winQ[15], 72'h0000001000000000);
    checkOutput("p1_done_timing", 72'(doneCyc), 72'(winCyc[15] + 1));

    // Random gaps, reset mid-frame, then a full gapped frame
    $display("[TB] gaps and mid-frame reset");
    is_conv3x3 = 1'b1;
    clearLog();
    for (int p = 0; p < 7; p++) begin
      applyStimulus(8'(p + 1), int'($urandom_range(0, 3)));
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_win", win, 72'h0);
    checkOutput("mid_rst_vld", 72'(vld_o), 72'(0));
    checkOutput("mid_rst_done", 72'(frame_done), 72'(0));
    checkOutput("mid_rst_rdy", 72'(rdy_o), 72'(1));
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    clearLog();
    sendFrame(3);
    waitDone("gap");
    checkOutput("gap_latency", 72'(winCyc[3]), 72'(accCyc[8]));
    checkRaster("gap");

    // Stride-2 request
    $display("[TB] stride2 frame");
    stride2 = 1'b1;
    clearLog();
    sendFrame(0);
    waitDone("s2");
    stride2 = 1'b0;
    expR.delete();
    expC.delete();
`ifdef SWG_STRIDE2_EN
    for (int r = 0; r < H; r += 2) begin
      for (int c = 0; c < W; c += 2) begin
        expR.push_back(r);
        expC.push_back(c);
      end
    end
`else
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        expR.push_back(r);
        expC.push_back(c);
      end
    end
`endif
    checkOutput("s2_count", 72'(winQ.size()), 72'(expR.size()));
    for (int i = 0; i < winQ.size() && i < expR.size(); i++) begin
      checkOutput($sformatf("s2_win%0d", i), winQ[i], goldWin(expR[i], expC[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sliding_window_gen.md
# sliding_window_gen

Streaming 3x3 window generator that turns a raster-order pixel stream into zero-padded 3x3 convolution windows, one window per pixel. It sits directly in front of the `conv_kern` bank: its window output drives each kernel's `din` in tap order, and its valid drives `vld_i`. It generalises to multiple channels, arbitrary frame size and a 1x1 bypass mode.

## Interface
- `WI`, 8, bits per pixel per channel
- `CH`, 1, channels packed per pixel
- `WIDTH`, 128, frame width in pixels (≥3)
- `HEIGHT`, 128, frame height in pixels (≥2)

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `is_conv3x3`  in  1  mode: 0 = 1x1 passthrough, 1 = 3x3 window
- `stride2`  in  1  stride-2 decimation request; used only with `SWG_STRIDE2_EN`
- `vld_i`  in  1  input pixel valid
- `rdy_o`  out  1  block can accept a pixel
- `din`  in  CH*WI  pixel; channel k at `[k*WI+:WI]`
- `win`  out  9*CH*WI  window; tap t at `[t*CH*WI+:CH*WI]`, t = (dy+1)*3+(dx+1)
- `vld_o`  out  1  window valid, one-cycle pulse per window
- `frame_done`  out  1  one-cycle pulse after the last window of a frame

## Operation
- A pixel is accepted on a cycle where `vld_i && rdy_o`. Pixels arrive in raster order, row 0 first, with arbitrary gaps between them.
- Column and row counters track accepted pixels. Pixel index is p = r*WIDTH + c.
- FSM:
  - IDLE → RUN on the first accepted pixel. `is_conv3x3` and `stride2` are sampled at this point and held for the whole frame.
  - RUN → FLUSH when pixel WIDTH*HEIGHT-1 is accepted in 3x3 mode. In 1x1 mode the FSM goes RUN → DONE instead.
  - FLUSH emits WIDTH+1 windows, one per cycle, then moves to DONE.
  - DONE lasts one cycle, pulses `frame_done`, then returns to IDLE.
- `rdy_o` = 1 in IDLE and RUN, 0 in FLUSH and DONE.
- Storage:
  - Two line buffers, each WIDTH deep and CH*WI wide, addressed by the column counter.
  - A 3x3 register array that shifts one column left per advance.
- 3x3 mode:
  - Window p is emitted when pixel p+WIDTH+1 is accepted.
  - The last WIDTH+1 windows are emitted during FLUSH.
  - Out-of-frame taps are 0: row −1, row HEIGHT, column −1, column WIDTH.
  - Padding is generated from the output-position counters, never from buffer contents, so stale data from a previous frame never appears in a window.
- 1x1 mode: tap 4 = pixel, all other taps = 0. Line buffers are unused.
- Each channel is handled independently with identical windowing. There is no arithmetic and no width change.
- Changing `is_conv3x3` mid-frame has no effect until the next IDLE → RUN transition.

## Timing
- Reset values: `win`=0, `vld_o`=0, `frame_done`=0, `rdy_o`=1, FSM=IDLE, all counters 0. Line buffers are not cleared.
- 1x1 latency: `vld_o`/`win` appear 1 cycle after acceptance.
- 3x3 latency: window p appears 1 cycle after acceptance of pixel p+WIDTH+1.
- FLUSH output is back-to-back, WIDTH+1 cycles. `frame_done` is asserted the cycle after the final `vld_o`.
- Input gaps do not alter window contents, only their timing.
- `rst` mid-frame: all outputs return to reset values immediately. The next accepted pixel is treated as pixel (0,0).
- `vld_i` while `rdy_o`=0 is ignored and the pixel is not consumed.

## Configuration
- `SWG_STRIDE2_EN` defined, with `stride2`=1 at frame start: `vld_o` is asserted only for windows whose centre has even row and even column. Window contents are unchanged, and `frame_done` timing is unchanged.
- `SWG_STRIDE2_EN` not defined: the `stride2` port exists but is ignored, and every window is emitted.

## Structure
- Package `swg_pkg` holds:
  - the tap-index constants (`TAP_NW`..`TAP_SE`, 0..8);
  - the FSM state typedef (IDLE, RUN, FLUSH, DONE);
  - the counter width helpers (`$clog2(WIDTH)`, `$clog2(HEIGHT)`).
- One sub-module, `swg_line_buf`: a single-clock RAM, depth WIDTH, width CH*WI, with one write and one read per cycle. It is instantiated twice.

## Test plan
All scenarios use WIDTH=4, HEIGHT=4, CH=1 and a ramp image where pixel(r,c) = r*4+c+1, unless stated otherwise.
- 3x3 corner: window (0,0) → taps 0,1,2,3,6 = 0; tap4=1, tap5=2, tap7=5, tap8=6.
- 3x3 interior: window (1,1) → taps 0..8 = 1,2,3,5,6,7,9,10,11. Window (3,3) → taps 0,1,3,4 = 11,12,15,16; all others 0.
- Flush: after the 16th pixel, `rdy_o`=0 for 6 cycles, 5 consecutive `vld_o` pulses, then one `frame_done` pulse. Total 16 windows.
- 1x1 mode: `din`=0x7F accepted → next cycle `vld_o`=1, tap4=0x7F, all other taps 0. `frame_done` follows the 16th window.
- Random `vld_i` gaps plus `rst` mid-frame after 7 pixels: window contents are identical to the gap-free run; after reset, outputs are 0 and `rdy_o`=1, and the following frame matches the golden windows.
- `SWG_STRIDE2_EN` with `stride2`=1: exactly 4 `vld_o` pulses, with centres (0,0), (0,2), (2,0), (2,2).
